// File: rtl/whack_game_core.sv
// whack_game_core: parametrised whack-a-mole engine with timed moles, miss limit and LFSR spawning
module whack_game_core #(
  parameter int NUM_HOLES = 9,
  parameter int SCORE_W = 8,
  parameter int MAX_MOLES = 2,
  parameter int TICK_DIV = 10_000_000,
  parameter int GAME_TICKS = 300,
  parameter int MOLE_LIFE = 8,
  parameter int MAX_MISSES = 5,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_game,
  input  logic                 hit_valid,
  input  logic [3:0]           hit_idx,
  output logic [NUM_HOLES-1:0] map,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [15:0]          time_left,
  output logic [1:0]           cur_state,
  output logic                 game_over
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int LW = $clog2(MOLE_LIFE + 1);
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;
  state_t state;
  logic [15:0] lfsr;
  logic [PW-1:0] presc;
  logic [NUM_HOLES-1:0][LW-1:0] life, life_n;
  logic [NUM_HOLES-1:0] map_n, hit_vec, spawn_vec;
  logic [7:0] spawn_idx;
  logic [4:0] pop, exp_cnt;
  logic [SCORE_W+4:0] miss_sum;
  logic [SCORE_W-1:0] score_n, misses_n;
  logic tick, spawn_ok, done;
  assign cur_state = state;
  assign tick = presc == PW'(TICK_DIV - 1);
  assign spawn_idx = lfsr[7:0] % 8'(NUM_HOLES);
  always_comb begin
    pop = '0;
    hit_vec = '0;
    spawn_vec = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      hit_vec[i] = hit_valid && hit_idx == 4'(i) && map[i];
      spawn_vec[i] = spawn_idx == 8'(i);
      pop = pop + 5'(map[i]);
    end
  end
  // eligibility and occupancy use the start-of-cycle map, so a hole freed this cycle cannot respawn
  assign spawn_ok = tick && pop < 5'(MAX_MOLES) && !(|(map & spawn_vec));
  always_comb begin
    map_n = map;
    life_n = life;
    exp_cnt = '0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      if (hit_vec[i]) begin
        map_n[i] = 1'b0;
        life_n[i] = '0;
      end else if (tick && map[i]) begin
        life_n[i] = life[i] - 1'b1;
        if (life[i] == LW'(1)) begin
          map_n[i] = 1'b0;
          exp_cnt = exp_cnt + 5'd1;
        end
      end
      if (spawn_ok && spawn_vec[i]) begin
        map_n[i] = 1'b1;
        life_n[i] = LW'(MOLE_LIFE);
      end
    end
  end
  assign miss_sum = {5'd0, misses} + {{SCORE_W{1'b0}}, exp_cnt};
  assign misses_n = miss_sum > {5'd0, {SCORE_W{1'b1}}} ? '1 : miss_sum[SCORE_W-1:0];
  assign score_n = (|hit_vec) && score != '1 ? score + 1'b1 : score;
  assign done = (tick && time_left == 16'd1) || miss_sum >= (SCORE_W + 5)'(MAX_MISSES);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lfsr <= SEED;
      presc <= '0;
      life <= '0;
      map <= '0;
      score <= '0;
      misses <= '0;
      time_left <= '0;
      game_over <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      game_over <= 1'b0;
      if (start_game) begin
        state <= PLAY;
        presc <= '0;
        life <= '0;
        map <= '0;
        score <= '0;
        misses <= '0;
        time_left <= 16'(GAME_TICKS);
      end else if (state == PLAY) begin
        presc <= tick ? '0 : presc + 1'b1;
        life <= life_n;
        score <= score_n;
        misses <= misses_n;
        time_left <= tick ? time_left - 16'd1 : time_left;
        map <= done ? '0 : map_n;
        if (done) begin
          state <= OVER;
          game_over <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_whack_game_core.sv
// tb_whack_game_core: directed and random stimulus against a hole-by-hole behavioural game model
module tb_whack_game_core;
  localparam int NUM_H = 9;
  localparam int TDIV = 4;
  localparam int GTICKS = 20;
  localparam int LIFE = 3;
  localparam int MOLES = 2;
  localparam int MAXM = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  logic clk, rst, start_game, hit_valid, game_over;
  logic [3:0] hit_idx;
  logic [NUM_H-1:0] map;
  logic [7:0] score, misses;
  logic [15:0] time_left;
  logic [1:0] cur_state;
  int passed = 0, total = 0, go_cnt = 0;
  int m_state, m_score, m_miss, m_time, m_pre, m_go;
  int m_life[NUM_H];
  logic [15:0] m_lfsr;

  whack_game_core #(
    .NUM_HOLES(NUM_H), .SCORE_W(8), .MAX_MOLES(MOLES), .TICK_DIV(TDIV),
    .GAME_TICKS(GTICKS), .MOLE_LIFE(LIFE), .MAX_MISSES(MAXM), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start_game(start_game), .hit_valid(hit_valid),
    .hit_idx(hit_idx), .map(map), .score(score), .misses(misses),
    .time_left(time_left), .cur_state(cur_state), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] lfsr_next(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [NUM_H-1:0] exp_map();
    logic [NUM_H-1:0] m = '0;
    for (int h = 0; h < NUM_H; h++) m[h] = m_life[h] > 0;
    return m;
  endfunction

  function automatic int find_life(int want);
    for (int h = 0; h < NUM_H; h++)
      if ((want < 0 && m_life[h] > 0) || (want >= 0 && m_life[h] == want)) return h;
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_score = 0; m_miss = 0; m_time = 0; m_pre = 0; m_go = 0;
    m_lfsr = SEED;
    foreach (m_life[h]) m_life[h] = 0;
  endtask

  // m_life[h] is the remaining lifetime of the mole in hole h; 0 means the hole is empty
  task automatic model_step(bit st, bit hv, logic [3:0] hi);
    int old[NUM_H];
    int up, sp;
    bit tk;
    m_go = 0;
    if (st) begin
      m_state = 1; m_score = 0; m_miss = 0; m_time = GTICKS; m_pre = 0;
      foreach (m_life[h]) m_life[h] = 0;
    end else if (m_state == 1) begin
      old = m_life;
      up = 0;
      foreach (old[h]) if (old[h] > 0) up++;
      sp = int'(m_lfsr[7:0]) % NUM_H;
      tk = m_pre == TDIV - 1;
      m_pre = tk ? 0 : m_pre + 1;
      if (hv && int'(hi) < NUM_H) begin
        if (old[hi] > 0) begin
          m_life[hi] = 0;
          m_score = m_score == 255 ? 255 : m_score + 1;
        end
      end
      if (tk) begin
        m_time--;
        for (int h = 0; h < NUM_H; h++)
          if (m_life[h] > 0) begin
            m_life[h]--;
            if (m_life[h] == 0) m_miss = m_miss == 255 ? 255 : m_miss + 1;
          end
        if (up < MOLES && old[sp] == 0) m_life[sp] = LIFE;
      end
      if (m_time == 0 || m_miss >= MAXM) begin
        m_state = 2; m_go = 1;
        foreach (m_life[h]) m_life[h] = 0;
      end
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  task automatic check_all();
    check("state", cur_state, m_state);
    check("map", map, exp_map());
    check("score", score, m_score);
    check("misses", misses, m_miss);
    check("time_left", time_left, m_time);
    check("game_over", game_over, m_go);
  endtask

  task automatic cyc(bit st, bit hv, logic [3:0] hi);
    start_game = st; hit_valid = hv; hit_idx = hi;
    @(posedge clk);
    model_step(st, hv, hi);
    #1;
    check_all();
    if (game_over) go_cnt++;
    @(negedge clk);
    start_game = 1'b0; hit_valid = 1'b0;
  endtask

  initial begin
    int h, n, ps, pm, extra;
    bit hv;
    logic [3:0] hi;
    rst = 1'b1; start_game = 1'b0; hit_valid = 1'b0; hit_idx = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("start_time", time_left, GTICKS);
    repeat (4) cyc(0, 0, 0);
    check("first_tick_time", time_left, GTICKS - 1);
    check("first_spawn_count", $countones(map), 1);
    h = find_life(-1);
    cyc(0, h >= 0, 4'(h));
    check("hit_score", score, 1);
    check("hit_cleared", map, '0);
    h = find_life(0);
    cyc(0, 1, 4'(h));
    cyc(0, 1, 4'd12);
    check("hit_oob_score", score, 1);
    go_cnt = 0;
    for (int i = 0; i < 200 && m_state == 1; i++) cyc(0, 0, 0);
    check("miss_over_state", cur_state, 2);
    check("miss_over_misses", misses, MAXM);
    check("miss_over_score", score, 1);
    check("miss_go_pulses", go_cnt, 1);
    cyc(0, 1, 4'd0);
    cyc(1, 0, 0);
    n = 0;
    for (int i = 0; i < 200 && n == 0; i++) begin
      h = find_life(1);
      if (m_pre == TDIV - 1 && h >= 0) begin
        ps = m_score; pm = m_miss; extra = 0;
        for (int k = 0; k < NUM_H; k++) if (k != h && m_life[k] == 1) extra++;
        cyc(0, 1, 4'(h));
        check("expiry_hit_score", score, ps + 1);
        check("expiry_hit_misses", misses, pm + extra);
        n = 1;
      end else cyc(0, 0, 0);
    end
    check("expiry_hit_found", n, 1);
    cyc(1, 0, 0);
    n = 0;
    go_cnt = 0;
    for (int i = 0; i < 120 && go_cnt == 0; i++) begin
      h = find_life(-1);
      cyc(0, h >= 0, h >= 0 ? 4'(h) : 4'd0);
      n++;
    end
    check("timer_cycles", n, GTICKS * TDIV);
    check("timer_state", cur_state, 2);
    check("timer_time", time_left, 0);
    check("timer_misses", misses, 0);
    cyc(1, 0, 0);
    check("restart_score", score, 0);
    check("restart_time", time_left, GTICKS);
    for (int i = 0; i < 2000; i++) begin
      h = find_life(-1);
      hv = $urandom_range(0, 1) == 1;
      hi = ($urandom_range(0, 2) == 0 || h < 0) ? 4'($urandom_range(0, 15)) : 4'(h);
      cyc(($urandom_range(0, 299) == 0) || (m_state != 1 && $urandom_range(0, 9) == 0), hv, hi);
    end
    cyc(1, 0, 0);
    repeat (7) cyc(0, 0, 0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("async_rst_state", cur_state, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (6) cyc(0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
